// File: rtl/fp_addsub_pkg.sv
// Shared constants and FSM state type for the two-requester add/sub scheduler.
package fp_addsub_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_LATENCY = 3;

    // Wide enough for the largest legal latency (15).
    localparam int CNT_W = 4;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    // NOTE: default assignment first so every path drives o_grant and no latch is inferred.
    always_comb begin
        o_grant = 2'b00;
        if (i_valid0 && i_valid1) begin
            o_grant = i_last ? 2'b01 : 2'b10;
        end else if (i_valid0) begin
            o_grant = 2'b01;
        end else if (i_valid1) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/fp_addsub_sched.sv
// Schedules two requesters onto one shared fixed-latency add/sub datapath,
// one operation in flight at a time, and returns the tagged result.
module fp_addsub_sched
    import fp_addsub_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic             req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic             req1_op,

    output logic [WIDTH-1:0] dp_x,
    output logic [WIDTH-1:0] dp_y,
    output logic             dp_op,
    output logic             dp_start,
    input  logic [WIDTH-1:0] dp_result,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    logic             r_dp_start;
    logic             r_dp_op;
    logic [WIDTH-1:0] r_dp_x;
    logic [WIDTH-1:0] r_dp_y;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_busy;

    logic [1:0]       w_grant;
    logic             w_offer;
    logic             w_sel;
    logic             w_accept;

    rr_arb2 u_arb (
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .i_last   (r_last),
        .o_grant  (w_grant)
    );

    // Readys are offered only from IDLE and never while reset is held.
    assign w_offer    = (r_state == IDLE) && !rst;
    assign req0_ready = w_offer && w_grant[0];
    assign req1_ready = w_offer && w_grant[1];
    assign w_sel      = w_grant[1];
    assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_dp_start  <= 1'b0;
            r_dp_op     <= OP_SUB;
            r_dp_x      <= '0;
            r_dp_y      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_dp_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dp_x     <= w_sel ? req1_x  : req0_x;
                        r_dp_y     <= w_sel ? req1_y  : req0_y;
                        r_dp_op    <= w_sel ? req1_op : req0_op;
                        r_last     <= w_sel;
                        r_dp_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    // WAIT spans LATENCY cycles; the last one is where the result is valid.
                    r_cnt   <= CNT_W'(LATENCY - 1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_data  <= dp_result;
                        r_rsp_id    <= r_last;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dp_x      = r_dp_x;
    assign dp_y      = r_dp_y;
    assign dp_op     = r_dp_op;
    assign dp_start  = r_dp_start;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Self-checking bench: transaction-level model compared every cycle, plus directed literal checks.
module tb_fp_addsub_sched;

    localparam int W   = 32;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         req0_valid, req0_ready, req0_op;
    logic [W-1:0] req0_x, req0_y;
    logic         req1_valid, req1_ready, req1_op;
    logic [W-1:0] req1_x, req1_y;
    logic [W-1:0] dp_x, dp_y, dp_result;
    logic         dp_op, dp_start;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [W-1:0] rsp_data;

    logic         l1_req0_valid, l1_req0_ready, l1_req0_op;
    logic [W-1:0] l1_req0_x, l1_req0_y;
    logic         l1_req1_valid, l1_req1_ready, l1_req1_op;
    logic [W-1:0] l1_req1_x, l1_req1_y;
    logic [W-1:0] l1_dp_x, l1_dp_y, l1_dp_result;
    logic         l1_dp_op, l1_dp_start;
    logic         l1_rsp_valid, l1_rsp_ready, l1_rsp_id, l1_busy;
    logic [W-1:0] l1_rsp_data;

    int cyc     = 0;
    int n_total = 0;
    int n_bad   = 0;

    fp_addsub_sched #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
        .dp_x(dp_x), .dp_y(dp_y), .dp_op(dp_op), .dp_start(dp_start), .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    fp_addsub_sched #(.WIDTH(W), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req0_valid(l1_req0_valid), .req0_ready(l1_req0_ready), .req0_x(l1_req0_x), .req0_y(l1_req0_y), .req0_op(l1_req0_op),
        .req1_valid(l1_req1_valid), .req1_ready(l1_req1_ready), .req1_x(l1_req1_x), .req1_y(l1_req1_y), .req1_op(l1_req1_op),
        .dp_x(l1_dp_x), .dp_y(l1_dp_y), .dp_op(l1_dp_op), .dp_start(l1_dp_start), .dp_result(l1_dp_result),
        .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_id(l1_rsp_id), .rsp_data(l1_rsp_data), .busy(l1_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stand-in for the real FP unit; the scheduler must pass its result through untouched.
    function automatic logic [31:0] fake_dp(input logic [31:0] x, input logic [31:0] y, input logic op);
        if (x == 32'h3F80_0000 && y == 32'h4000_0000)
            return op ? 32'h4040_0000 : 32'hBF80_0000;
        return op ? x + y : x - y;
    endfunction

    // Datapath responders: result is valid only in the cycle exactly LATENCY after dp_start.
    int           dp_due = -1, l1_due = -1;
    int           last_start = -1, l1_last_start = -1;
    logic [31:0]  dp_pend = '0, l1_pend = '0;

    always @(negedge clk) begin
        dp_result = (cyc == dp_due) ? dp_pend : 32'hDEAD_BEEF;
        if (dp_start === 1'b1) begin
            dp_due     = cyc + LAT;
            dp_pend    = fake_dp(dp_x, dp_y, dp_op);
            last_start = cyc;
        end
        l1_dp_result = (cyc == l1_due) ? l1_pend : 32'hDEAD_BEEF;
        if (l1_dp_start === 1'b1) begin
            l1_due        = cyc + 1;
            l1_pend       = fake_dp(l1_dp_x, l1_dp_y, l1_dp_op);
            l1_last_start = cyc;
        end
    end

    // Transaction model: one op in flight, timestamps relative to the accept cycle.
    bit          m_inflight = 0, m_have = 0, m_last = 1;
    int          m_acc = 0;
    logic [31:0] m_x, m_y;
    logic        m_op, m_id;
    logic        exp_r0, exp_r1, exp_start, exp_rv;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
            check("rst_dp_start", dp_start, 0);
            check("rst_dp_x", dp_x, 0);
            check("rst_dp_y", dp_y, 0);
            check("rst_dp_op", dp_op, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_id", rsp_id, 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_busy", busy, 0);
            m_inflight = 0;
            m_have     = 0;
            m_last     = 1;
        end else begin
            exp_r0 = !m_inflight && req0_valid && (!req1_valid || m_last == 1'b1);
            exp_r1 = !m_inflight && req1_valid && (!req0_valid || m_last == 1'b0);
            exp_start = m_inflight && (cyc == m_acc + 1);
            exp_rv    = m_inflight && (cyc >= m_acc + LAT + 2);
            check("m_ready0", req0_ready, exp_r0);
            check("m_ready1", req1_ready, exp_r1);
            check("m_dp_start", dp_start, exp_start);
            check("m_rsp_valid", rsp_valid, exp_rv);
            check("m_busy", busy, m_inflight);
            check("m_dp_x", dp_x, m_have ? m_x : 32'h0);
            check("m_dp_y", dp_y, m_have ? m_y : 32'h0);
            check("m_dp_op", dp_op, m_have ? m_op : 1'b0);
            if (exp_rv) begin
                check("m_rsp_id", rsp_id, m_id);
                check("m_rsp_data", rsp_data, fake_dp(m_x, m_y, m_op));
            end
            if (exp_rv && rsp_ready) begin
                m_inflight = 0;
            end else if (exp_r0 || exp_r1) begin
                m_inflight = 1;
                m_have     = 1;
                m_acc      = cyc;
                m_id       = exp_r1;
                m_last     = exp_r1;
                m_x        = exp_r1 ? req1_x  : req0_x;
                m_y        = exp_r1 ? req1_y  : req0_y;
                m_op       = exp_r1 ? req1_op : req0_op;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic issue(input bit id, input logic [31:0] x, input logic [31:0] y, input logic op,
                         output int acc);
        @(posedge clk); #1;
        if (id) begin req1_valid = 1; req1_x = x; req1_y = y; req1_op = op; end
        else    begin req0_valid = 1; req0_x = x; req0_y = y; req0_op = op; end
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("issue_timeout", 0, 1);
        @(posedge clk); #1;
        // Scramble inputs after the handshake; the DUT must not look at them again.
        if (id) begin req1_valid = 0; req1_x = '1; req1_y = '1; req1_op = ~op; end
        else    begin req0_valid = 0; req0_x = '1; req0_y = '1; req0_op = ~op; end
    endtask

    task automatic wait_rsp(output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("rsp_timeout", 0, 1);
    endtask

    int ids[4];
    int accs[4];

    initial begin
        int a, t, n_resp, n_acc, quiet;
        logic [31:0] held;
        req0_valid = 1; req0_x = '0; req0_y = '0; req0_op = 0;
        req1_valid = 1; req1_x = '0; req1_y = '0; req1_op = 0;
        rsp_ready  = 0;
        l1_req0_valid = 1; l1_req0_x = '0; l1_req0_y = '0; l1_req0_op = 0;
        l1_req1_valid = 0; l1_req1_x = '0; l1_req1_y = '0; l1_req1_op = 0;
        l1_rsp_ready  = 1;

        // Reset with both requesters asserting: readys must stay low.
        repeat (2) @(negedge clk);
        check("rst_ready0_lit", req0_ready, 0);
        check("rst_ready1_lit", req1_ready, 0);
        check("l1_rst_ready0", l1_req0_ready, 0);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0; l1_req0_valid = 0;
        rst = 0; rsp_ready = 1;

        // req0 add: dp_start at +1, rsp_valid at +5.
        issue(0, 32'h3F80_0000, 32'h4000_0000, 1'b1, a);
        wait_rsp(t);
        check("add_start_cyc", last_start, a + 1);
        check("add_rsp_cyc", t, a + LAT + 2);
        check("add_rsp_id", rsp_id, 0);
        check("add_rsp_data", rsp_data, 32'h4040_0000);

        // req1 subtract.
        issue(1, 32'h3F80_0000, 32'h4000_0000, 1'b0, a);
        wait_rsp(t);
        check("sub_dp_op", dp_op, 0);
        check("sub_rsp_cyc", t, a + LAT + 2);
        check("sub_rsp_id", rsp_id, 1);
        check("sub_rsp_data", rsp_data, 32'hBF80_0000);

        // Both requesters held valid for four operations.
        do_reset();
        req0_x = 32'd1;  req0_y = 32'd2; req0_op = 1;
        req1_x = 32'd10; req1_y = 32'd3; req1_op = 0;
        req0_valid = 1; req1_valid = 1;
        n_resp = 0; n_acc = 0;
        for (int i = 0; i < 100 && n_resp < 4; i++) begin
            @(negedge clk);
            if ((req0_ready || req1_ready) && n_acc < 4) begin
                accs[n_acc] = cyc;
                n_acc++;
            end
            if (rsp_valid && rsp_ready) begin
                ids[n_resp] = rsp_id;
                n_resp++;
            end
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        check("rr_count", n_resp, 4);
        check("rr_id0", ids[0], 0);
        check("rr_id1", ids[1], 1);
        check("rr_id2", ids[2], 0);
        check("rr_id3", ids[3], 1);
        check("rr_interval", accs[1] - accs[0], LAT + 3);

        // Back-pressure for 10 cycles with NaN/Inf operands and a competing request.
        rsp_ready = 0;
        issue(0, 32'h7FC0_0000, 32'h7F80_0000, 1'b1, a);
        check("nan_dp_x", dp_x, 32'h7FC0_0000);
        check("inf_dp_y", dp_y, 32'h7F80_0000);
        req1_valid = 1; req1_x = 32'd5; req1_y = 32'd6; req1_op = 1;
        wait_rsp(t);
        held = rsp_data;
        check("bp_data", held, 32'hFF40_0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_stable", rsp_data, held);
            check("bp_ready0", req0_ready, 0);
            check("bp_ready1", req1_ready, 0);
            check("bp_start", dp_start, 0);
        end
        @(posedge clk); #1;
        req1_valid = 0; rsp_ready = 1;
        repeat (2) @(negedge clk);
        check("bp_drained", rsp_valid, 0);

        // Reset during WAIT discards the operation.
        issue(1, 32'h0000_0000, 32'h8000_0000, 1'b0, a);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_dp_x", dp_x, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_ready1", req1_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        quiet = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b0) quiet++;
        end
        check("abort_no_rsp", quiet, 8);
        issue(0, 32'h3F80_0000, 32'h4000_0000, 1'b1, a);
        wait_rsp(t);
        check("restart_start_cyc", last_start, a + 1);
        check("restart_rsp_cyc", t, a + LAT + 2);
        check("restart_data", rsp_data, 32'h4040_0000);

        // LATENCY = 1 instance.
        @(posedge clk); #1;
        l1_req0_valid = 1; l1_req0_x = 32'h3F80_0000; l1_req0_y = 32'h4000_0000; l1_req0_op = 1;
        a = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (l1_req0_ready) begin a = cyc; break; end
        end
        if (a < 0) check("l1_issue_timeout", 0, 1);
        @(posedge clk); #1;
        l1_req0_valid = 0;
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (l1_rsp_valid) begin t = cyc; break; end
        end
        if (t < 0) check("l1_rsp_timeout", 0, 1);
        check("l1_start_cyc", l1_last_start, a + 1);
        check("l1_rsp_cyc", t, a + 3);
        check("l1_rsp_data", l1_rsp_data, 32'h4040_0000);
        check("l1_rsp_id", l1_rsp_id, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fp_addsub_sched.md
FP_ADDSUB_SCHED -- requirements
Module: fp_addsub_sched

Interface
REQ-001 Parameter WIDTH, default 32, is the operand/result width (IEEE-754 single).
REQ-002 Parameter LATENCY, default 3, is the fixed datapath latency in cycles from dp_start to a valid dp_result; legal range 1..15.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-006 req0_ready / req1_ready  output  1  requester N's operation is accepted this cycle.
REQ-007 req0_x, req0_y / req1_x, req1_y  input  WIDTH  operands of requester N.
REQ-008 req0_op / req1_op  input  1  operation select: 1 = x+y, 0 = x-y.
REQ-009 dp_x, dp_y  output  WIDTH  operands driven to the shared add/sub datapath.
REQ-010 dp_op  output  1  operation select driven to the datapath, same encoding as REQ-008.
REQ-011 dp_start  output  1  one-cycle pulse launching a datapath operation.
REQ-012 dp_result  input  WIDTH  datapath result, valid exactly LATENCY cycles after dp_start.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_id  output  1  index of the requester that owns the response.
REQ-016 rsp_data  output  WIDTH  result of the operation.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, START, WAIT, RESP; only one operation is in flight at a time.
REQ-019 IDLE: if any req valid, grant one requester; reqN_ready is high combinationally only in IDLE and only for the granted requester; otherwise both readys are low.
REQ-020 Arbitration is 2-way round-robin: if both are valid, grant the requester not granted last; if only one is valid, grant it regardless of history.
REQ-021 On request handshake (valid & ready), latch x, y, op and id into internal registers and go to START.
REQ-022 START (one cycle): dp_start = 1; dp_x/dp_y/dp_op come from the latched registers and stay stable until the next grant; load the wait counter; go to WAIT.
REQ-023 WAIT: count down; in the cycle LATENCY cycles after the dp_start cycle, sample dp_result into rsp_data and go to RESP.
REQ-024 RESP: rsp_valid = 1, rsp_data/rsp_id held stable until rsp_ready; on rsp_valid & rsp_ready go to IDLE.
REQ-025 Timing for LATENCY = 3: request accepted cycle 0, dp_start cycle 1, result sampled cycle 4, rsp_valid from cycle 5; minimum issue interval is LATENCY+3 cycles.
REQ-026 rsp_ready held high before rsp_valid has no effect; back-pressure in RESP stalls indefinitely with no loss.
REQ-027 Requests arriving outside IDLE are not accepted (ready low) and must be held by the requester; requester inputs are not sampled except on handshake.
REQ-028 Operands pass through unmodified; the block performs no arithmetic on data, including NaN/Inf/zero encodings.

Reset
REQ-029 rst asserted (any time, including mid-operation): state = IDLE, in-flight operation discarded, round-robin pointer set so req0 wins the first tie.
REQ-030 Reset values: req0_ready = req1_ready = 0 while rst is high, dp_start = 0, dp_x = dp_y = 0, dp_op = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0.

Structure
REQ-031 Shared package fp_addsub_pkg holds WIDTH default, LATENCY default, the FSM state enum, and constants OP_ADD = 1, OP_SUB = 0.
REQ-032 The round-robin grant logic is one sub-module, rr_arb2 (inputs two valids plus the last-grant pointer, output a one-hot grant); the top holds FSM, counter and registers.

Verification
REQ-033 req0: x = 0x3F800000, y = 0x40000000, op = 1; datapath model returns 0x40400000 -> dp_start at cycle 1, rsp_valid at cycle 5, rsp_id = 0, rsp_data = 0x40400000.
REQ-034 req1: same operands, op = 0; model returns 0xBF800000 -> dp_op = 0, rsp_id = 1, rsp_data = 0xBF800000.
REQ-035 Both valid continuously for 4 operations -> grants alternate 0,1,0,1; the first grant goes to req0 after reset.
REQ-036 rsp_ready held low for 10 cycles in RESP -> rsp_valid and rsp_data stable, both req readys low, no dp_start pulse.
REQ-037 rst asserted during WAIT -> all outputs at reset values next cycle, no response emitted, next request handshake restarts at cycle 0 timing.
REQ-038 LATENCY = 1 build: request accepted cycle 0 -> dp_start cycle 1, sample cycle 2, rsp_valid cycle 3.
